// File: rtl/zuc256_sched_pkg.sv
// Shared definitions for the ZUC-256 message scheduler: FSM states, command codes,
// datapath widths and the legal MAC tag lengths.
package zuc256_sched_pkg;

   localparam int WORD_BITS  = 32;
   localparam int BLOCK_BITS = 128;

   localparam logic [7:0] TAG_LEN_32  = 8'd32;
   localparam logic [7:0] TAG_LEN_64  = 8'd64;
   localparam logic [7:0] TAG_LEN_128 = 8'd128;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_KINIT = 4'd1,
      S_KWAIT = 4'd2,
      S_FETCH = 4'd3,
      S_CWAIT = 4'd4,
      S_EMIT  = 4'd5,
      S_FIN   = 4'd6,
      S_FWAIT = 4'd7,
      S_TAG   = 4'd8
   } state_e;

   typedef enum logic [1:0] {
      CMD_INIT  = 2'd0,
      CMD_NEXT  = 2'd1,
      CMD_FINAL = 2'd2
   } cmd_e;

   function automatic logic tag_len_ok(input logic [7:0] t);
      return (t == TAG_LEN_32) || (t == TAG_LEN_64) || (t == TAG_LEN_128);
   endfunction

endpackage

// File: rtl/zuc256_cmd_pulse.sv
// One-cycle command strobe towards zuc256_tot; hides tot_ready for the pulse cycle
// and the cycle after it, then reports the first ready as core-done.
module zuc256_cmd_pulse
   import zuc256_sched_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_fire,
   input  cmd_e i_cmd,
   input  logic i_ready,
   output logic o_init,
   output logic o_next,
   output logic o_final,
   output logic o_core_done
);

   logic r_pulse;
   logic r_pulse_d;
   logic r_wait;
   cmd_e r_cmd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pulse   <= 1'b0;
         r_pulse_d <= 1'b0;
         r_wait    <= 1'b0;
         r_cmd     <= CMD_INIT;
      end else if (i_clr) begin
         r_pulse   <= 1'b0;
         r_pulse_d <= 1'b0;
         r_wait    <= 1'b0;
      end else begin
         r_pulse   <= i_fire;
         r_pulse_d <= r_pulse;
         if (i_fire) begin
            r_cmd  <= i_cmd;
            r_wait <= 1'b1;
         end else if (o_core_done) begin
            r_wait <= 1'b0;
         end
      end
   end

   assign o_core_done = r_wait & ~r_pulse & ~r_pulse_d & i_ready;
   assign o_init      = r_pulse & (r_cmd == CMD_INIT);
   assign o_next      = r_pulse & (r_cmd == CMD_NEXT);
   assign o_final     = r_pulse & (r_cmd == CMD_FINAL);

endmodule

// File: rtl/zuc256_msg_sched.sv
// Message-level sequencer for zuc256_tot: streams 32-bit words (encrypt) or
// 128-bit blocks (MAC) through the core and returns keystream words or the tag.
module zuc256_msg_sched
   import zuc256_sched_pkg::*;
#(
   parameter int MLEN_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              enc_auth,
   input  logic [MLEN_W-1:0] msg_len,
   input  logic [7:0]        tag_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              tot_init,
   output logic              tot_next,
   output logic              tot_final,
   output logic              tot_enc_auth,
   output logic [127:0]      tot_block_i,
   output logic [7:0]        tot_i_len,
   output logic [7:0]        tot_tag_len,
   input  logic [127:0]      tot_block_o,
   input  logic              tot_ready,
   output logic [3:0]        dbg_state
);

   // Valid/ready: a beat transfers on a rising edge where valid and ready are both
   // high; valid is held with stable data until then, ready may change freely.

   state_e              r_state;
   state_e              w_next_state;
   logic                r_mac;
   logic [MLEN_W-1:0]   r_rem;
   logic [7:0]          r_tag_len;
   logic [7:0]          r_chunk;
   logic [7:0]          r_i_len;
   logic [127:0]        r_blk;
   logic [127:0]        r_out;
   logic                r_done;
   logic                r_error;

   logic                w_fire;
   cmd_e                w_cmd;
   logic                w_latch;
   logic                w_take;
   logic                w_cap_enc;
   logic                w_cap_tag;
   logic                w_set_done;
   logic                w_set_err;
   logic                w_core_done;
   logic [7:0]          w_chunk;
   logic [31:0]         w_in_mask;
   logic [31:0]         w_out_mask;

   zuc256_cmd_pulse u_cmd_pulse (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_clr       (abort),
      .i_fire      (w_fire),
      .i_cmd       (w_cmd),
      .i_ready     (tot_ready),
      .o_init      (tot_init),
      .o_next      (tot_next),
      .o_final     (tot_final),
      .o_core_done (w_core_done)
   );

   // Chunk never exceeds rem, so the remaining-bit counter cannot wrap.
   always_comb begin
      w_chunk = 8'd0;
      if (r_mac) begin
         w_chunk = (r_rem >= MLEN_W'(BLOCK_BITS)) ? 8'(BLOCK_BITS) : 8'(r_rem);
      end else begin
         w_chunk = (r_rem >= MLEN_W'(WORD_BITS)) ? 8'(WORD_BITS) : 8'(r_rem);
      end
   end

   assign w_in_mask  = ~(32'hFFFF_FFFF >> w_chunk);
   assign w_out_mask = ~(32'hFFFF_FFFF >> r_chunk);

   always_comb begin
      w_next_state = r_state;
      w_fire       = 1'b0;
      w_cmd        = CMD_INIT;
      w_latch      = 1'b0;
      w_take       = 1'b0;
      w_cap_enc    = 1'b0;
      w_cap_tag    = 1'b0;
      w_set_done   = 1'b0;
      w_set_err    = 1'b0;
      if (abort) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_latch = 1'b1;
                  if (!tag_len_ok(tag_len)) begin
                     w_set_done = 1'b1;
                     w_set_err  = 1'b1;
                  end else begin
                     w_fire       = 1'b1;
                     w_cmd        = CMD_INIT;
                     w_next_state = S_KINIT;
                  end
               end
            end
            S_KINIT: w_next_state = S_KWAIT;
            S_KWAIT: begin
               if (w_core_done) begin
                  if (r_rem != '0) begin
                     w_next_state = S_FETCH;
                  end else if (r_mac) begin
                     w_fire       = 1'b1;
                     w_cmd        = CMD_FINAL;
                     w_next_state = S_FIN;
                  end else begin
                     w_set_done   = 1'b1;
                     w_next_state = S_IDLE;
                  end
               end
            end
            S_FETCH: begin
               if (in_valid) begin
                  w_take       = 1'b1;
                  w_fire       = 1'b1;
                  w_cmd        = CMD_NEXT;
                  w_next_state = S_CWAIT;
               end
            end
            S_CWAIT: begin
               if (w_core_done) begin
                  if (!r_mac) begin
                     w_cap_enc    = 1'b1;
                     w_next_state = S_EMIT;
                  end else if (r_rem != '0) begin
                     w_next_state = S_FETCH;
                  end else begin
                     w_fire       = 1'b1;
                     w_cmd        = CMD_FINAL;
                     w_next_state = S_FIN;
                  end
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  if (r_rem != '0) begin
                     w_next_state = S_FETCH;
                  end else begin
                     w_set_done   = 1'b1;
                     w_next_state = S_IDLE;
                  end
               end
            end
            S_FIN: w_next_state = S_FWAIT;
            S_FWAIT: begin
               if (w_core_done) begin
                  w_cap_tag    = 1'b1;
                  w_next_state = S_TAG;
               end
            end
            S_TAG: begin
               if (out_ready) begin
                  w_set_done   = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mac     <= 1'b0;
         r_rem     <= '0;
         r_tag_len <= 8'd0;
         r_chunk   <= 8'd0;
         r_i_len   <= 8'd0;
         r_blk     <= '0;
         r_out     <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= w_set_done;
         r_error <= w_set_err;
         if (w_latch) begin
            r_mac     <= enc_auth;
            r_rem     <= msg_len;
            r_tag_len <= tag_len;
         end
         if (w_take) begin
            r_blk   <= r_mac ? in_data : {96'h0, in_data[31:0] & w_in_mask};
            r_chunk <= w_chunk;
            r_i_len <= w_chunk;
            r_rem   <= r_rem - MLEN_W'(w_chunk);
         end
         // The final command always carries an empty block length.
         if (w_fire && (w_cmd == CMD_FINAL)) r_i_len <= 8'd0;
         if (w_cap_enc) r_out <= {96'h0, tot_block_o[31:0] & w_out_mask};
         if (w_cap_tag) r_out <= tot_block_o;
      end
   end

   assign in_ready     = (r_state == S_FETCH) & ~abort;
   assign out_valid    = (r_state == S_EMIT) | (r_state == S_TAG);
   assign out_data     = r_out;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign error        = r_error;
   assign tot_enc_auth = r_mac;
   assign tot_block_i  = r_blk;
   assign tot_i_len    = r_i_len;
   assign tot_tag_len  = r_tag_len;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_zuc256_msg_sched.sv
// Bench for zuc256_msg_sched: a toy zuc256_tot stand-in, random messages, and a
// scoreboard of expected output beats, block lengths and done/error pulses.
module tb_zuc256_msg_sched;
   import zuc256_sched_pkg::*;

   localparam int MLEN_W = 16;
   localparam logic [127:0] ACC_INIT = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              start, abort, enc_auth, in_valid, in_ready, out_valid, out_ready;
   logic [MLEN_W-1:0] msg_len;
   logic [7:0]        tag_len;
   logic [127:0]      in_data, out_data;
   logic              busy, done, error, tot_init, tot_next, tot_final, tot_enc_auth;
   logic [127:0]      tot_block_i, tot_block_o;
   logic [7:0]        tot_i_len, tot_tag_len;
   logic              tot_ready;
   logic [3:0]        dbg_state;

   int                n_checks = 0;
   int                n_errors = 0;
   logic [127:0]      exp_q[$];
   logic [7:0]        exp_len_q[$];
   bit                exp_err_q[$];
   int                done_cnt = 0, init_cnt = 0, next_cnt = 0, in_ready_cnt = 0;
   bit                bp_force = 1'b0;

   always #5 clk = ~clk;

   zuc256_msg_sched #(.MLEN_W(MLEN_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .enc_auth(enc_auth),
      .msg_len(msg_len), .tag_len(tag_len), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .error(error), .tot_init(tot_init), .tot_next(tot_next),
      .tot_final(tot_final), .tot_enc_auth(tot_enc_auth), .tot_block_i(tot_block_i),
      .tot_i_len(tot_i_len), .tot_tag_len(tot_tag_len), .tot_block_o(tot_block_o),
      .tot_ready(tot_ready), .dbg_state(dbg_state)
   );

   function automatic logic [31:0] ks(input logic [31:0] n);
      return n * 32'h9E37_79B9 + 32'h0123_4567;
   endfunction

   function automatic logic [127:0] rotl1(input logic [127:0] a);
      return {a[126:0], a[127]};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Toy core: keystream word per next in encrypt mode, rotate-xor accumulator in MAC mode.
   logic [127:0] acc, pend;
   logic [31:0]  ks_n;
   int           lat;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tot_ready <= 1'b1; tot_block_o <= '0; acc <= '0; pend <= '0; ks_n <= '0; lat <= 0;
      end else if (tot_init || tot_next || tot_final) begin
         tot_ready <= 1'b0;
         lat       <= $urandom_range(1, 4);
         if (tot_init) begin
            acc <= ACC_INIT; ks_n <= '0; pend <= '0;
         end else if (tot_next) begin
            if (tot_enc_auth) begin
               acc <= rotl1(acc) ^ tot_block_i ^ {120'h0, tot_i_len};
               pend <= {$urandom, $urandom, $urandom, $urandom};
            end else begin
               pend <= {$urandom, $urandom, $urandom, tot_block_i[31:0] ^ ks(ks_n)};
               ks_n <= ks_n + 1;
            end
         end else begin
            pend <= acc ^ {tot_tag_len, 120'h0};
         end
      end else if (lat > 0) begin
         lat <= lat - 1;
         if (lat == 1) begin
            tot_ready <= 1'b1; tot_block_o <= pend;
         end
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard queues whenever the DUT presents an event.
   bit           prev_pulse = 1'b0, prev_stall = 1'b0;
   logic [127:0] prev_data;
   logic [127:0] e128;
   logic [7:0]   e8;
   bit           eb;
   int           npulse;
   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", 128'(exp_q.size()), 128'd1);
            else begin
               e128 = exp_q.pop_front();
               chk("out_data", out_data, e128);
            end
         end
         if (prev_stall && out_valid) chk("out_stable", out_data, prev_data);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         npulse = int'(tot_init) + int'(tot_next) + int'(tot_final);
         if (npulse != 0) begin
            chk("cmd_excl", {prev_pulse, 8'(npulse)}, {1'b0, 8'd1});
            if (tot_next || tot_final) begin
               if (exp_len_q.size() == 0) chk("len_unexpected", 128'(exp_len_q.size()), 128'd1);
               else begin
                  e8 = exp_len_q.pop_front();
                  chk(tot_final ? "final_i_len" : "next_i_len", 128'(tot_i_len), 128'(e8));
               end
            end
         end
         prev_pulse = (npulse != 0);
         if (tot_init) init_cnt++;
         if (tot_next) next_cnt++;
         if (in_ready) in_ready_cnt++;
         if (done) begin
            done_cnt++;
            if (exp_err_q.size() == 0) chk("done_unexpected", 128'(exp_err_q.size()), 128'd1);
            else begin
               eb = exp_err_q.pop_front();
               chk("done_error", 128'(error), 128'(eb));
            end
         end else if (error) begin
            chk("error_without_done", 128'(done), 128'd1);
         end
      end
   end

   task automatic drive_blk(input logic [127:0] blk);
      int g;
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1; in_data = blk; g = 0;
      while (!in_ready && g < 3000) begin @(negedge clk); g++; end
      chk("fetch_ready", 128'(in_ready), 128'd1);
      @(negedge clk);
      in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic run_msg(input bit mac, input int len, input logic [7:0] tl);
      logic [127:0] blks[$];
      logic [127:0] blk, accm;
      logic [31:0]  m, ones;
      int           rem, chunk, k, target, budget;
      bit           legal;
      ones  = 32'hFFFF_FFFF;
      legal = (tl == 8'd32) || (tl == 8'd64) || (tl == 8'd128);
      accm  = ACC_INIT; rem = len; k = 0;
      if (legal) begin
         while (rem > 0) begin
            chunk = mac ? ((rem > 128) ? 128 : rem) : ((rem > 32) ? 32 : rem);
            blk = {$urandom, $urandom, $urandom, $urandom};
            blks.push_back(blk);
            exp_len_q.push_back(8'(chunk));
            if (mac) accm = rotl1(accm) ^ blk ^ 128'(chunk);
            else begin
               m = ones << (32 - chunk);
               exp_q.push_back({96'h0, ((blk[31:0] & m) ^ ks(32'(k))) & m});
               k++;
            end
            rem -= chunk;
         end
         if (mac) begin
            exp_len_q.push_back(8'h0);
            exp_q.push_back(accm ^ {tl, 120'h0});
         end
      end
      exp_err_q.push_back(!legal);
      target = done_cnt + 1;
      @(negedge clk);
      start = 1'b1; enc_auth = mac; msg_len = MLEN_W'(len); tag_len = tl;
      @(negedge clk);
      start = 1'b0;
      foreach (blks[i]) drive_blk(blks[i]);
      budget = 0;
      while (done_cnt < target && budget < 3000) begin @(negedge clk); budget++; end
      chk("run_done", 128'(done_cnt >= target), 128'd1);
   endtask

   task automatic bp_watch();
      int           g, nc;
      logic [127:0] hold;
      g = 0;
      while (dbg_state != S_EMIT && g < 2000) begin @(negedge clk); g++; end
      chk("bp_reach_emit", 128'(dbg_state), 128'(S_EMIT));
      hold = out_data; nc = next_cnt;
      repeat (5) begin
         @(negedge clk);
         chk("bp_data_stable", out_data, hold);
         chk("bp_valid_held", 128'(out_valid), 128'd1);
      end
      chk("bp_no_next", 128'(next_cnt), 128'(nc));
      bp_force = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int ic, nc, rc, dc, g;
      logic [7:0] tls [3];
      tls[0] = 8'd32; tls[1] = 8'd64; tls[2] = 8'd128;
      start = 0; abort = 0; enc_auth = 0; msg_len = '0; tag_len = '0;
      in_valid = 0; in_data = '0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_state", 128'(dbg_state), 128'(S_IDLE));
      chk("rst_flags", 128'({busy, done, error, in_ready, out_valid}), 128'd0);
      chk("rst_cmds", 128'({tot_init, tot_next, tot_final, tot_enc_auth}), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_block_i", tot_block_i, 128'd0);
      chk("rst_lens", 128'({tot_i_len, tot_tag_len}), 128'd0);

      nc = next_cnt; run_msg(1'b0, 64, 8'd32);
      chk("enc64_nexts", 128'(next_cnt - nc), 128'd2);
      nc = next_cnt; run_msg(1'b0, 40, 8'd32);
      chk("enc40_nexts", 128'(next_cnt - nc), 128'd2);
      run_msg(1'b1, 300, 8'd64);
      ic = init_cnt; rc = in_ready_cnt;
      run_msg(1'b1, 0, 8'd128);
      chk("mac0_init", 128'(init_cnt - ic), 128'd1);
      chk("mac0_no_in_ready", 128'(in_ready_cnt), 128'(rc));

      ic = init_cnt;
      exp_err_q.push_back(1'b1);
      @(negedge clk); start = 1'b1; enc_auth = 1'b1; msg_len = 16'd100; tag_len = 8'd48;
      @(negedge clk); start = 1'b0;
      chk("bad_tag_pulse", 128'({done, error}), 128'd3);
      @(negedge clk);
      chk("bad_tag_one_cycle", 128'({done, error, busy}), 128'd0);
      chk("bad_tag_no_init", 128'(init_cnt), 128'(ic));

      exp_len_q.push_back(8'd32);
      @(negedge clk); start = 1'b1; enc_auth = 1'b0; msg_len = 16'd64; tag_len = 8'd32;
      @(negedge clk); start = 1'b0;
      drive_blk({$urandom, $urandom, $urandom, $urandom});
      g = 0;
      while (dbg_state != S_CWAIT && g < 2000) begin @(negedge clk); g++; end
      chk("abort_reach_cwait", 128'(dbg_state), 128'(S_CWAIT));
      dc = done_cnt;
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_idle", 128'(dbg_state), 128'(S_IDLE));
      chk("abort_flags", 128'({busy, done, out_valid, tot_next}), 128'd0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", 128'(done_cnt), 128'(dc));
      ic = init_cnt;
      run_msg(1'b0, 40, 8'd64);
      chk("abort_reinit", 128'(init_cnt - ic), 128'd1);

      bp_force = 1'b1;
      fork
         run_msg(1'b0, 64, 8'd128);
         bp_watch();
      join

      for (int r = 0; r < 10; r++) begin
         run_msg(1'($urandom_range(0, 1)), $urandom_range(0, 700), tls[$urandom_range(0, 2)]);
      end

      repeat (5) @(negedge clk);
      chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
      chk("len_q_drained", 128'(exp_len_q.size()), 128'd0);
      chk("err_q_drained", 128'(exp_err_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
